// File: rtl/decodificador_hamming_pipe_if.sv
// Codeword-in / corrected-word-out handshake bundle for decodificador_hamming_pipe.
// HAMMING_SECDED_EN widens in_cw by the overall-parity bit.
interface decodificador_hamming_pipe_if #(
  parameter int DATA_W = 8
);
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((1 << p) < (dw + p + 1)) p = p + 1;
    return p;
  endfunction

  localparam int P = calc_p(DATA_W);
  localparam int N = DATA_W + P;
`ifdef HAMMING_SECDED_EN
  localparam int CW_W = N + 1;
`else
  localparam int CW_W = N;
`endif

  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   in_cw;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [P-1:0]      out_syndrome;
  logic              out_err_corr;
  logic              out_err_uncorr;

  modport master (
    output in_valid, in_cw, out_ready,
    input  in_ready, out_valid, out_data, out_syndrome, out_err_corr, out_err_uncorr
  );

  modport slave (
    input  in_valid, in_cw, out_ready,
    output in_ready, out_valid, out_data, out_syndrome, out_err_corr, out_err_uncorr
  );
endinterface

// File: rtl/decodificador_hamming_pipe.sv
// Two-stage pipelined Hamming SEC decoder with error flags and saturating counters.
// Define HAMMING_SECDED_EN for SEC-DED (overall parity bit, double-error detection).
module decodificador_hamming_pipe #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  decodificador_hamming_pipe_if.slave bus,
  input  logic                        cnt_clr,
  output logic [CNT_W-1:0]            cnt_corr,
  output logic [CNT_W-1:0]            cnt_uncorr
);
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((1 << p) < (dw + p + 1)) p = p + 1;
    return p;
  endfunction

  localparam int P = calc_p(DATA_W);
  localparam int N = DATA_W + P;
  localparam logic [P-1:0] N_S = P'(N);

  logic              v1_q;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [P-1:0]      syn1_q, syn1_d;
`ifdef HAMMING_SECDED_EN
  logic              p0_q, p0_d;
`endif
  logic              v2_q;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic [P-1:0]      syn2_q;
  logic              corr2_q, corr2_d;
  logic              uncorr2_q, uncorr2_d;
  logic              flip;
  logic [CNT_W-1:0]  cnt_corr_q, cnt_uncorr_q;
  logic              load2, in_ready, hs_in, hs_out;

  assign load2    = !v2_q | bus.out_ready;
  assign in_ready = !v1_q | load2;
  assign hs_in    = bus.in_valid & in_ready;
  assign hs_out   = v2_q & bus.out_ready;

  // Syndrome bit k collects every position whose index has bit k set.
  always_comb begin
    int j;
    syn1_d  = '0;
    data1_d = '0;
    j = 0;
    for (int i = 1; i <= N; i++) begin
      for (int k = 0; k < P; k++)
        if (i[k]) syn1_d[k] = syn1_d[k] ^ bus.in_cw[i-1];
      if ((i & (i - 1)) != 0) begin
        data1_d[j] = bus.in_cw[i-1];
        j = j + 1;
      end
    end
  end

`ifdef HAMMING_SECDED_EN
  assign p0_d = ^bus.in_cw;
`endif

  always_comb begin
    int j;
    flip      = 1'b0;
    corr2_d   = 1'b0;
    uncorr2_d = 1'b0;
`ifdef HAMMING_SECDED_EN
    if (syn1_q == '0) begin
      corr2_d = p0_q;
    end else if (!p0_q) begin
      uncorr2_d = 1'b1;
    end else if (syn1_q <= N_S) begin
      corr2_d = 1'b1;
      flip    = 1'b1;
    end else begin
      uncorr2_d = 1'b1;
    end
`else
    if (syn1_q != '0 && syn1_q <= N_S) begin
      corr2_d = 1'b1;
      flip    = 1'b1;
    end else if (syn1_q > N_S) begin
      uncorr2_d = 1'b1;
    end
`endif
    // A parity-position syndrome matches no data slot, so data is left as-is.
    data2_d = data1_q;
    j = 0;
    for (int i = 1; i <= N; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (flip && syn1_q == P'(i)) data2_d[j] = ~data2_d[j];
        j = j + 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      data1_q <= '0;
      syn1_q  <= '0;
`ifdef HAMMING_SECDED_EN
      p0_q    <= 1'b0;
`endif
    end else if (in_ready) begin
      v1_q <= bus.in_valid;
      if (hs_in) begin
        data1_q <= data1_d;
        syn1_q  <= syn1_d;
`ifdef HAMMING_SECDED_EN
        p0_q    <= p0_d;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q      <= 1'b0;
      data2_q   <= '0;
      syn2_q    <= '0;
      corr2_q   <= 1'b0;
      uncorr2_q <= 1'b0;
    end else if (load2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        data2_q   <= data2_d;
        syn2_q    <= syn1_q;
        corr2_q   <= corr2_d;
        uncorr2_q <= uncorr2_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else if (cnt_clr) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else if (hs_out) begin
      if (corr2_q && !(&cnt_corr_q))     cnt_corr_q   <= cnt_corr_q + CNT_W'(1);
      if (uncorr2_q && !(&cnt_uncorr_q)) cnt_uncorr_q <= cnt_uncorr_q + CNT_W'(1);
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = v2_q;
  assign bus.out_data       = data2_q;
  assign bus.out_syndrome   = syn2_q;
  assign bus.out_err_corr   = corr2_q;
  assign bus.out_err_uncorr = uncorr2_q;
  assign cnt_corr           = cnt_corr_q;
  assign cnt_uncorr         = cnt_uncorr_q;
endmodule
